// File: rtl/hps_fpga_pio_strobe.sv
// Avalon-MM PIO with data/set/clear registers and a timed XOR pulse on selected bits.
// Define HPS_FPGA_PIO_STROBE_IRQ_EN to add the irq output and the STATUS irq_en bit.
module hps_fpga_pio_strobe #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned PULSE_CNT_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
`ifdef HPS_FPGA_PIO_STROBE_IRQ_EN
  output logic                  irq,
`endif
  output logic                  pulse_busy
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                     state_q, state_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [DATA_WIDTH-1:0]      mask_q, mask_d;
  logic [DATA_WIDTH-1:0]      mask_lat_q, mask_lat_d;
  logic [PULSE_CNT_WIDTH-1:0] len_q, len_d;
  logic [PULSE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic                       irq_en_q, irq_en_d;

  logic                       wr;
  logic                       go;
  logic [PULSE_CNT_WIDTH-1:0] len_eff;
  logic [DATA_WIDTH-1:0]      wdata;
  logic                       unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign go           = wr && (address == 3'd5) && writedata[0];
  assign wdata        = writedata[DATA_WIDTH-1:0];
  assign len_eff      = (len_q == '0) ? PULSE_CNT_WIDTH'(1) : len_q;
  assign unused_wdata = ^writedata;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mask_d     = mask_q;
    mask_lat_d = mask_lat_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    irq_en_d   = irq_en_q;

    if (wr) begin
      case (address)
        3'd0: data_d = wdata;
        3'd1: data_d = data_q | wdata;
        3'd2: data_d = data_q & ~wdata;
        3'd3: mask_d = wdata;
        3'd4: len_d  = writedata[PULSE_CNT_WIDTH-1:0];
        3'd6: begin
          if (writedata[1]) done_d = 1'b0;
`ifdef HPS_FPGA_PIO_STROBE_IRQ_EN
          irq_en_d = writedata[2];
`endif
        end
        default: ;
      endcase
    end

    // GO wins over natural expiry, so a retrigger on the last cycle never reports done.
    if (go) begin
      state_d    = StActive;
      cnt_d      = len_eff;
      mask_lat_d = mask_q;
    end else if (state_q == StActive) begin
      if (cnt_q == PULSE_CNT_WIDTH'(1)) begin
        state_d = StIdle;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - PULSE_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      mask_lat_q <= '0;
      len_q      <= PULSE_CNT_WIDTH'(1);
      cnt_q      <= '0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      mask_lat_q <= mask_lat_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      irq_en_q   <= irq_en_d;
    end
  end

  assign pulse_busy = (state_q == StActive);
  assign out_port   = data_q ^ (pulse_busy ? mask_lat_q : '0);

`ifdef HPS_FPGA_PIO_STROBE_IRQ_EN
  assign irq = done_q & irq_en_q;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[DATA_WIDTH-1:0]      = data_q;
      3'd3: readdata[DATA_WIDTH-1:0]      = mask_q;
      3'd4: readdata[PULSE_CNT_WIDTH-1:0] = len_q;
      3'd5: readdata[0]                   = pulse_busy;
      3'd6: readdata[2:0]                 = {irq_en_q, done_q, pulse_busy};
      default: ;
    endcase
  end

endmodule
